// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus between one initiator and one target.
// The master modport drives the cycle, the slave modport answers it.
interface wb_bus_t;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_ms;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_sm;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        input  wb_ack, wb_err, wb_dat_sm
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_ms,
        output wb_ack, wb_err, wb_dat_sm
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-transfer Wishbone classic master: one command in, one bus cycle, one response out.
// An optional watchdog aborts bus cycles that the slave never terminates.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    wb_bus_t.master     wb_bus
);

    localparam int unsigned ADR_W   = 32;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_to_q, rsp_to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    // State and all registered bus/response outputs
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic; err outranks ack, ack outranks the watchdog
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    sel_d   = req_sel_i;
                    dat_d   = req_we_i ? req_dat_i : '0;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_bus.wb_err) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end else if (wb_bus.wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_bus.wb_dat_sm;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_dat_o        = rsp_dat_q;
    assign rsp_err_o        = rsp_err_q;
    assign rsp_timeout_o    = rsp_to_q;
    assign wb_bus.wb_cyc    = cyc_q;
    assign wb_bus.wb_stb    = cyc_q;
    assign wb_bus.wb_we     = we_q;
    assign wb_bus.wb_adr    = adr_q;
    assign wb_bus.wb_sel    = sel_q;
    assign wb_bus.wb_dat_ms = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: stimulus queues expected responses,
// a monitor pops them on every response handshake; a slave model answers bus cycles.
module tb_wb_cmd_master;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } rsp_t;

    logic        clk;
    logic        rstn_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;

    wb_bus_t bus ();

    wb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_adr_i     (req_adr),
        .req_sel_i     (req_sel),
        .req_dat_i     (req_dat),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy),
        .wb_bus        (bus.master)
    );

    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    // Slave model knobs: ack on bus cycle index slv_wait (-1 = never answer)
    int          slv_wait = 0;
    logic        slv_err  = 1'b0;
    logic [31:0] slv_dat  = '0;
    logic        late_ack = 1'b0;
    int          bus_cycles = 0;
    int          last_len = 0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: answers at negedge so the master samples at the following posedge
    always @(negedge clk) begin
        if (bus.wb_cyc && bus.wb_stb) begin
            if (bus_cycles == 0) begin
                cap_adr = bus.wb_adr;
                cap_we  = bus.wb_we;
                cap_sel = bus.wb_sel;
                cap_dat = bus.wb_dat_ms;
            end else begin
                check("bus_stable", {bus.wb_adr, bus.wb_dat_ms},
                      {cap_adr, cap_dat});
                check("bus_stable_ctl", 64'({bus.wb_we, bus.wb_sel}),
                      64'({cap_we, cap_sel}));
            end
            if (bus_cycles == slv_wait) begin
                bus.wb_ack    = 1'b1;
                bus.wb_err    = slv_err;
                bus.wb_dat_sm = slv_dat;
            end else begin
                bus.wb_ack = 1'b0;
                bus.wb_err = 1'b0;
            end
            bus_cycles++;
        end else begin
            if (bus_cycles != 0) last_len = bus_cycles;
            bus_cycles = 0;
            bus.wb_ack = late_ack;
            bus.wb_err = 1'b0;
        end
    end

    // Monitor: every response handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rstn_i && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit push, input rsp_t exp);
        bit ok;
        @(posedge clk); #1;
        req_we    = we;
        req_adr   = adr;
        req_sel   = sel;
        req_dat   = dat;
        req_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(name, 64'(0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        rsp_t e;
        bit   seen;
        rstn_i        = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_adr       = '0;
        req_sel       = '0;
        req_dat       = '0;
        rsp_ready     = 1'b1;
        bus.wb_ack    = 1'b0;
        bus.wb_err    = 1'b0;
        bus.wb_dat_sm = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn_i = 1'b1;
        @(negedge clk);
        check("rst_cyc", 64'({bus.wb_cyc, bus.wb_stb}), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_adr", 64'(bus.wb_adr), 64'(0));

        // Write, slave acks in the first bus cycle
        slv_wait = 0; slv_err = 1'b0; slv_dat = 32'h0;
        e = '{dat: 32'h0, err: 1'b0, to: 1'b0};
        send(1'b1, 32'h4, 4'hF, 32'h0000_1234, 1'b1, e);
        @(negedge clk);
        check("wr_cyc1", 64'({bus.wb_cyc, bus.wb_stb, bus.wb_we}), 64'(3'b111));
        check("wr_adr", 64'(bus.wb_adr), 64'(32'h4));
        check("wr_dat_ms", 64'(bus.wb_dat_ms), 64'(32'h1234));
        check("wr_sel", 64'(bus.wb_sel), 64'(4'hF));
        @(negedge clk);
        check("wr_cyc_drop", 64'(bus.wb_cyc), 64'(0));
        check("wr_rsp_latency", 64'(rsp_valid), 64'(1));
        @(negedge clk);
        check("wr_len", 64'(last_len), 64'(1));

        // Read with three wait states
        slv_wait = 3; slv_dat = 32'hDEAD_BEEF;
        e = '{dat: 32'hDEAD_BEEF, err: 1'b0, to: 1'b0};
        send(1'b0, 32'h8, 4'hF, 32'hFFFF_FFFF, 1'b1, e);
        @(negedge clk);
        check("rd_adr", 64'(bus.wb_adr), 64'(32'h8));
        check("rd_we", 64'(bus.wb_we), 64'(0));
        check("rd_dat_ms_zero", 64'(bus.wb_dat_ms), 64'(0));
        wait_rsp(20, "rd_rsp_timeout");
        @(negedge clk);
        check("rd_len", 64'(last_len), 64'(4));

        // Slave error with simultaneous ack
        slv_wait = 0; slv_err = 1'b1; slv_dat = 32'h1111_2222;
        e = '{dat: 32'h0, err: 1'b1, to: 1'b0};
        send(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, e);
        wait_rsp(20, "err_rsp_timeout");
        @(negedge clk);
        slv_err = 1'b0;

        // Watchdog abort, then a late ack that must be ignored
        slv_wait = -1;
        e = '{dat: 32'h0, err: 1'b1, to: 1'b1};
        send(1'b0, 32'h30, 4'hF, 32'h0, 1'b1, e);
        wait_rsp(40, "to_rsp_timeout");
        @(negedge clk);
        check("to_len", 64'(last_len), 64'(16));
        late_ack = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wb_cyc || rsp_valid) seen = 1'b1;
        end
        check("late_ack_ignored", 64'(seen), 64'(0));
        late_ack = 1'b0;

        // Backpressure on read data 0x55 with a second request already waiting
        slv_wait = 0; slv_dat = 32'h55;
        @(posedge clk); #1 rsp_ready = 1'b0;
        e = '{dat: 32'h55, err: 1'b0, to: 1'b0};
        send(1'b0, 32'h8, 4'hF, 32'h0, 1'b1, e);
        req_we = 1'b1; req_adr = 32'hC; req_sel = 4'h3; req_dat = 32'hAA;
        req_valid = 1'b1;
        e = '{dat: 32'h0, err: 1'b0, to: 1'b0};
        exp_q.push_back(e);
        wait_rsp(20, "bp_rsp_timeout");
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_dat}),
                  64'({3'b100, 32'h55}));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_not_same_cycle", 64'({req_ready, bus.wb_cyc}), 64'(2'b10));
        @(negedge clk);
        check("b2b_accept", 64'({bus.wb_cyc, bus.wb_we}), 64'(2'b11));
        check("b2b_adr", 64'(bus.wb_adr), 64'(32'hC));
        @(posedge clk); #1 req_valid = 1'b0;
        wait_rsp(20, "b2b_rsp_timeout");
        @(negedge clk);

        // Reset in the middle of a bus cycle discards the response
        slv_wait = -1;
        e = '{dat: 32'h0, err: 1'b0, to: 1'b0};
        send(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, e);
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(bus.wb_cyc), 64'(1));
        @(posedge clk); #1 rstn_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cyc", 64'({bus.wb_cyc, bus.wb_stb}), 64'(0));
        check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1 rstn_i = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 64'(req_ready), 64'(1));
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || bus.wb_cyc) seen = 1'b1;
        end
        check("mid_no_rsp", 64'(seen), 64'(0));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
